// File: rtl/cdb_pkg.sv
// Shared types and constants for the common data bus arbiter.
package cdb_pkg;

  localparam int REQ_INT    = 0;
  localparam int REQ_MULT   = 1;
  localparam int REQ_DIV    = 2;
  localparam int REQ_MEM    = 3;
  localparam int CDB_TAG_W  = 6;
  localparam int CDB_DATA_W = 32;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic                  branch;
    logic                  branch_taken;
    logic                  jalr;
  } cdb_result_t;

  // Pointer width that stays at least one bit for a single requester.
  function automatic int cdb_ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set req at or after ptr, with wrap modulo N.
module rr_priority_pick
  import cdb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = cdb_ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic        found;
  int unsigned sel;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sel   = 0;
    for (int k = 0; k < N; k++) begin
      sel = (int'(ptr) + k) % N;
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        idx      = PW'(sel);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus; registers the winner's result.
// Define CDB_BRANCH_PRIORITY_EN to favour branch/jalr results over other requests.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ-1:0]        req_branch,
  input  logic [N_REQ-1:0]        req_branch_taken,
  input  logic [N_REQ-1:0]        req_jalr,
  output logic [N_REQ-1:0]        gnt,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic                    cdb_branch,
  output logic                    cdb_branch_taken,
  output logic                    cdb_jalr
);

  localparam int PW = cdb_ptr_w(N_REQ);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              branch;
    logic              branch_taken;
    logic              jalr;
  } res_t;

  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  res_t             res_q, res_d;
  logic [N_REQ-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;

`ifdef CDB_BRANCH_PRIORITY_EN
  logic [N_REQ-1:0] cf_req, cf_gnt, all_gnt;
  logic [PW-1:0]    cf_idx, all_idx;

  assign cf_req = req & (req_branch | req_jalr);

  rr_priority_pick #(.N(N_REQ), .PW(PW)) u_pick_cf (
    .req (cf_req),
    .ptr (rr_ptr_q),
    .gnt (cf_gnt),
    .idx (cf_idx)
  );

  rr_priority_pick #(.N(N_REQ), .PW(PW)) u_pick_all (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (all_gnt),
    .idx (all_idx)
  );

  assign pick_gnt = (|cf_req) ? cf_gnt : all_gnt;
  assign pick_idx = (|cf_req) ? cf_idx : all_idx;
`else
  rr_priority_pick #(.N(N_REQ), .PW(PW)) u_pick_all (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );
`endif

  assign gnt = rst ? pick_gnt : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    res_d    = '0;
    if (|gnt) begin
      rr_ptr_d           = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
      res_d.valid        = 1'b1;
      res_d.tag          = req_tag[int'(pick_idx)*TAG_W +: TAG_W];
      res_d.data         = req_data[int'(pick_idx)*DATA_W +: DATA_W];
      // jalr outranks branch; taken only means something on a branch
      res_d.jalr         = req_jalr[pick_idx];
      res_d.branch       = req_branch[pick_idx] & ~req_jalr[pick_idx];
      res_d.branch_taken = req_branch_taken[pick_idx] & res_d.branch;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      res_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      res_q    <= res_d;
    end
  end

  assign cdb_valid        = res_q.valid;
  assign cdb_tag          = res_q.tag;
  assign cdb_data         = res_q.data;
  assign cdb_branch       = res_q.branch;
  assign cdb_branch_taken = res_q.branch_taken;
  assign cdb_jalr         = res_q.jalr;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ-1:0]        req_branch, req_branch_taken, req_jalr;
  logic [N_REQ-1:0]        gnt;
  logic                    cdb_valid, cdb_branch, cdb_branch_taken, cdb_jalr;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  cdb_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .req_data         (req_data),
    .req_tag          (req_tag),
    .req_branch       (req_branch),
    .req_branch_taken (req_branch_taken),
    .req_jalr         (req_jalr),
    .gnt              (gnt),
    .cdb_valid        (cdb_valid),
    .cdb_tag          (cdb_tag),
    .cdb_data         (cdb_data),
    .cdb_branch       (cdb_branch),
    .cdb_branch_taken (cdb_branch_taken),
    .cdb_jalr         (cdb_jalr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    if (!done) begin
      n_fail++;
      $error("FAIL timeout: stimulus did not complete");
      $finish;
    end
  end

  initial begin
    logic [N_REQ-1:0] exp_g;
    rst              = 1'b0;
    req              = 4'b1111;
    req_branch       = '0;
    req_branch_taken = '0;
    req_jalr         = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_tag[i*TAG_W +: TAG_W]    = TAG_W'(i + 1);
      req_data[i*DATA_W +: DATA_W] = 32'h1000_0000 + i;
    end

    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_valid", cdb_valid, 1'b0);
    end
    rst = 1'b1;
    #1;

    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      chk("rot_gnt", gnt, exp_g);
      tick();
      chk("rot_valid", cdb_valid, 1'b1);
      chk("rot_tag", cdb_tag, TAG_W'((k % 4) + 1));
    end

    req = 4'b0100;
    #1;
    chk("wrap_pre_gnt", gnt, 4'b0100);
    tick();
    chk("wrap_pre_tag", cdb_tag, 6'h03);
    req = 4'b0011;
    #1;
    chk("wrap_gnt", gnt, 4'b0001);
    tick();
    chk("wrap_tag", cdb_tag, 6'h01);

    req_data[2*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    req_tag[2*TAG_W +: TAG_W]    = 6'h2A;
    req = 4'b0110;
    #1;
    chk("hold_mult_gnt", gnt, 4'b0010);
    tick();
    chk("hold_mult_tag", cdb_tag, 6'h02);
    req = 4'b0100;
    #1;
    chk("hold_div_gnt", gnt, 4'b0100);
    tick();
    chk("hold_div_data", cdb_data, 32'hDEAD_BEEF);
    chk("hold_div_tag", cdb_tag, 6'h2A);
    chk("hold_div_valid", cdb_valid, 1'b1);

    req = 4'b0000;
    #1;
    chk("idle_gnt", gnt, 4'b0000);
    tick();
    chk("idle_valid", cdb_valid, 1'b0);
    chk("idle_branch", cdb_branch, 1'b0);

    req = 4'b0001;
    req_branch_taken = 4'b0001;
    #1;
    chk("mask_gnt", gnt, 4'b0001);
    tick();
    chk("mask_branch", cdb_branch, 1'b0);
    chk("mask_taken", cdb_branch_taken, 1'b0);
    req_branch = 4'b0001;
    tick();
    chk("br_branch", cdb_branch, 1'b1);
    chk("br_taken", cdb_branch_taken, 1'b1);
    req_jalr = 4'b0001;
    tick();
    chk("jalr_jalr", cdb_jalr, 1'b1);
    chk("jalr_branch", cdb_branch, 1'b0);
    chk("jalr_taken", cdb_branch_taken, 1'b0);
    req_branch = '0;
    req_branch_taken = '0;
    req_jalr = '0;

    rst = 1'b0;
    #1;
    chk("midrst_gnt", gnt, 4'b0000);
    tick();
    chk("midrst_valid", cdb_valid, 1'b0);
    rst = 1'b1;

    req = 4'b0011;
    req_branch = 4'b0010;
    #1;
`ifdef CDB_BRANCH_PRIORITY_EN
    chk("prio_gnt", gnt, 4'b0010);
    tick();
    chk("prio_branch", cdb_branch, 1'b1);
`else
    chk("prio_gnt", gnt, 4'b0001);
    tick();
    chk("prio_branch", cdb_branch, 1'b0);
`endif
    req_branch = '0;

    req = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("single_gnt", gnt, 4'b1000);
      tick();
      chk("single_tag", cdb_tag, 6'h04);
    end

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single common data bus (CDB) among the execution units: integer, multiply, divide and memory.
- Grants one requester per cycle using a rotating round-robin priority.
- Registers the winning result onto the CDB record consumed by the dispatch unit, tag FIFO, register status table, register file and issue queues.
- A requester not granted holds its result and request until granted.

Parameters:
N_REQ, 4, number of requesting execution units (index 0 int, 1 mult, 2 div, 3 mem)
DATA_W, 32, result data width
TAG_W, 6, rename tag width (matches 64-entry tag FIFO)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-low reset
req  input  N_REQ  per-unit result-ready request
req_data  input  N_REQ*DATA_W  per-unit result data, unit i at [i*DATA_W +: DATA_W]
req_tag  input  N_REQ*TAG_W  per-unit destination tag
req_branch  input  N_REQ  result is a resolved branch
req_branch_taken  input  N_REQ  resolved branch taken
req_jalr  input  N_REQ  result is a resolved jalr target
gnt  output  N_REQ  one-hot grant, combinational, same cycle as req
cdb_valid  output  1  registered CDB valid
cdb_tag  output  TAG_W  registered CDB tag
cdb_data  output  DATA_W  registered CDB data
cdb_branch  output  1  registered branch-resolved flag
cdb_branch_taken  output  1  registered branch-taken flag
cdb_jalr  output  1  registered jalr-resolved flag

Behaviour:
- Reset (rst==0 at clk edge): rr_ptr=0; all cdb_* outputs 0. gnt forced to 0 while rst==0.
- Grant: gnt is one-hot or zero. Winner is the first asserted req scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...). No req → gnt=0.
- Handshake: requester keeps req and payload stable until it sees gnt[i]=1 in a cycle. That cycle's clock edge is the transfer. The unit may drop req or present a new result in the next cycle. Dropping req without a grant is legal: the request is withdrawn and nothing is recorded.
- Pointer: on a cycle with any grant to index g, rr_ptr ← (g+1) mod N_REQ. No grant → rr_ptr holds.
- Latency: one cycle. Grant in cycle N → cdb_* valid in cycle N+1 with the granted payload. No grant in cycle N → cdb_valid=0 in cycle N+1.
- Flags when idle: cdb_branch, cdb_branch_taken and cdb_jalr are all 0 whenever cdb_valid=0.
- Flag masking: cdb_branch_taken=0 unless cdb_branch=1 (req_branch_taken is masked with req_branch). cdb_branch and cdb_jalr are never both 1; if a requester sets both, jalr wins and branch is cleared.
- Throughput: at most one result per cycle. Back-to-back grants to different units are allowed every cycle.
- Fairness: any continuously asserted req is granted within N_REQ cycles.
- Single requester: granted every cycle it asserts req.
- Reset mid-transfer: a grant issued in the same cycle that reset is sampled is discarded; cdb_valid=0 in the next cycle.
- rr_ptr is ceil(log2(N_REQ)) bits. Wrap uses modulo N_REQ, so non-power-of-two N_REQ is supported.

Optional Feature:
CDB_BRANCH_PRIORITY_EN
- Defined:
  - Requests with req_branch|req_jalr form a high-priority set.
  - If the set is non-empty, the winner is picked round-robin from that set only, using the same rr_ptr.
  - Pointer update is unchanged: rr_ptr ← g+1.
  - Purpose: shortens dispatch stall after branches and jalr.
  - Starvation bound for normal requests: N_REQ cycles after the last control-flow request clears.
- Undefined: pure round-robin over all requests; control-flow flags are carried but have no effect on arbitration.

Decomposition:
- Package cdb_pkg:
  - typedef struct packed cdb_result_t {tag, data, branch, branch_taken, jalr}
  - localparams REQ_INT=0, REQ_MULT=1, REQ_DIV=2, REQ_MEM=3, CDB_TAG_W=6, CDB_DATA_W=32
- One sub-module, rr_priority_pick: combinational N-way round-robin pick.
  - Inputs: req vector, pointer.
  - Output: one-hot grant plus encoded index.
  - Instantiated once, or twice when CDB_BRANCH_PRIORITY_EN is defined (control-flow set and full set, selected by whether the control-flow set is non-empty).
- Pointer register and output register stay in cdb_arbiter.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req=4'b1111 → gnt=0, cdb_valid=0. After release, first grant goes to unit 0.
- Full contention: req=4'b1111 held, distinct tags 0x01..0x04 → gnt sequence 0001,0010,0100,1000,0001. cdb_tag 0x01,0x02,0x03,0x04 appears one cycle after each grant.
- Pointer wrap: rr_ptr=3 (after granting unit 2), req=4'b0011 → gnt=4'b0001, then rr_ptr=1.
- Hold semantics: mult (idx 1) and div (idx 2) both request, div data 0xDEADBEEF tag 0x2A → mult granted first, div granted next cycle. cdb_data=0xDEADBEEF and cdb_tag=0x2A in the cycle after div's grant.
- Flag masking: int request with req_branch=0, req_branch_taken=1 → cdb_branch=0, cdb_branch_taken=0. Same request with req_branch=1 → both flags 1.
- CDB_BRANCH_PRIORITY_EN: rr_ptr=0, req=4'b0011, only unit 1 has req_branch=1 → gnt=4'b0010 first. Without the macro → gnt=4'b0001 first.
